arb2_mux_sel_ctrl: RTL and testbench
====================================

Name: arb2_mux_sel_ctrl

Overview:
- Two-requester round-robin arbiter that generates the select for a downstream 2:1 mux datapath.
- Sits directly upstream of the 2:1 mux. It accepts two valid/ready streams (A, B), grants one at a time, and drives `sel`.
- It also presents the selected data through a registered valid/ready output stage, bounding burst length per grant for fairness.

Parameters:
- DATA_W, 8, width of each input and output data word
- HOLD_MAX, 4, maximum beats accepted per grant before re-arbitration (>=1)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a_valid  input  1  requester A has data
- a_data  input  DATA_W  requester A data
- a_ready  output  1  A beat accepted this cycle when high with a_valid
- b_valid  input  1  requester B has data
- b_data  input  DATA_W  requester B data
- b_ready  output  1  B beat accepted this cycle when high with b_valid
- y_valid  output  1  output register holds a beat
- y_data  output  DATA_W  output data
- y_ready  input  1  consumer accepts y_data
- sel  output  1  mux select: 0=A, 1=B; registered
- busy  output  1  high whenever state != IDLE or y_valid

Behaviour:
- Reset (async assert, sync release): state=IDLE, sel=0, last=B (so A wins first tie), beat_cnt=0, y_valid=0, y_data=0. Combinational readies evaluate to 0.
- States:
  - IDLE: no grant.
  - GNT_A: sel=0.
  - GNT_B: sel=1.
- accept = !y_valid | y_ready.
- a_ready = accept & (state==GNT_A); b_ready = accept & (state==GNT_B). Never both high.
- IDLE transitions:
  - only a_valid -> GNT_A; only b_valid -> GNT_B.
  - both valid -> the requester != last.
  - neither -> stay in IDLE; sel holds its last value.
- GNT_x:
  - On each transfer (x_valid & x_ready): y_data<=x_data, y_valid<=1, beat_cnt++.
  - Release when x_valid==0, or when a transfer occurs with beat_cnt==HOLD_MAX-1.
  - On release: last<=x, beat_cnt<=0. Next state = other requester if its valid is high, else GNT_x again if x_valid (limit hit, no contender), else IDLE.
  - No IDLE bubble when switching requester.
- Output stage:
  - y_valid clears on y_ready when no new transfer occurs in the same cycle.
  - y_data and y_valid stay stable while y_valid & !y_ready.
- Latency: from IDLE, x_valid rising -> y_valid 2 cycles later (grant cycle + register cycle). In steady grant, throughput is 1 beat/cycle with y_ready held high.
- Backpressure: y_ready low with y_valid high -> readies low, no state or count change, grant held.
- Input requirement: requesters keep x_valid/x_data stable until accepted. The block does not check this.
- Reset mid-burst: all state is dropped immediately and the in-flight beat in the output register is lost.
- HOLD_MAX=1: strict alternation whenever both requesters are valid.
- beat_cnt width: $clog2(HOLD_MAX+1).

Optional Feature:
- Macro: ARB2_STATS_EN.
- Defined:
  - Adds outputs `gnt_cnt_a` and `gnt_cnt_b` (16 bits each), counting accepted beats per requester.
  - Counters reset to 0, saturate at 16'hFFFF, and add no latency.
- Undefined: ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package `arb2_pkg`:
  - state enum constants IDLE=2'd0, GNT_A=2'd1, GNT_B=2'd2.
  - SEL_A=1'b0, SEL_B=1'b1.
- One natural sub-module: `out_reg_stage` (valid/ready holding register, DATA_W wide), instantiated once.
- Arbitration FSM and beat counter stay in the top level.

Test Plan:
- Reset: hold rst_n=0 with a_valid=b_valid=1 -> y_valid=0, sel=0, a_ready=b_ready=0. Release -> GNT_A next cycle, y_data=A's first word 2 cycles after release.
- Single requester A: a_valid=1 continuous, data 0x10..0x17, y_ready=1, HOLD_MAX=4, b_valid=0 -> 8 beats out in order at 1 beat/cycle, sel stays 0, no gap at the 4-beat limit.
- Contention: a_valid=b_valid=1 continuous, y_ready=1, HOLD_MAX=4 -> 4 A beats, 4 B beats, 4 A beats; sel toggles exactly at beat boundaries; no idle cycle between grants.
- Backpressure: during GNT_B, drop y_ready for 3 cycles -> y_data frozen, b_ready=0, beat_cnt unchanged. Restore -> stream resumes with no loss or duplicate.
- Idle tie-break: after B's grant ends and both are idle, raise a_valid and b_valid in the same cycle -> A granted first (last=B).
- Async reset mid-burst: assert rst_n=0 between clock edges in GNT_B with y_valid=1 -> y_valid, sel and readies go 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/arb2_pkg.sv
// Shared definitions for the two-requester round-robin mux-select arbiter.
package arb2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } arb_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage : arb2_pkg

// File: rtl/arb2_mux_sel_ctrl_out_reg_stage.sv
// Valid/ready holding register for the arbiter output beat.
// Loads on i_load, drains on i_ready, holds while stalled.
module out_reg_stage #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_accept
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // Space for a new beat when empty or when the held beat leaves this cycle.
    always_comb begin
        o_accept = !r_valid || i_ready;
    end

    // Load a new beat, otherwise drop the held one once the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule : out_reg_stage

// File: rtl/arb2_mux_sel_ctrl.sv
// Two-requester round-robin arbiter driving the select of a downstream 2:1 mux,
// with a registered valid/ready output stage and a per-grant burst limit.
// Optional per-requester beat counters are enabled by defining ARB2_STATS_EN.
module arb2_mux_sel_ctrl
    import arb2_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              y_valid,
    output logic [DATA_W-1:0] y_data,
    input  logic              y_ready,
    output logic              sel,
    output logic              busy
`ifdef ARB2_STATS_EN
    ,
    output logic [15:0]       gnt_cnt_a,
    output logic [15:0]       gnt_cnt_b
`endif
);

    localparam int unsigned          CNT_W     = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0]     LAST_BEAT = CNT_W'(HOLD_MAX - 1);

    arb_state_t        r_state;
    logic              r_sel;
    logic              r_last;
    logic [CNT_W-1:0]  r_beat_cnt;

    logic              w_accept;
    logic              w_a_xfer;
    logic              w_b_xfer;
    logic              w_load;
    logic [DATA_W-1:0] w_load_data;

    // Readies, transfer strobes and the beat steered into the output register.
    always_comb begin
        a_ready     = w_accept && (r_state == GNT_A);
        b_ready     = w_accept && (r_state == GNT_B);
        w_a_xfer    = a_valid && a_ready;
        w_b_xfer    = b_valid && b_ready;
        w_load      = w_a_xfer || w_b_xfer;
        w_load_data = (r_state == GNT_B) ? b_data : a_data;
    end

    // Arbitration FSM: grant, burst counting and release with round-robin priority.
    // A release goes straight to the contender's grant so switching costs no cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_sel      <= SEL_A;
            r_last     <= SEL_B;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (a_valid && (!b_valid || (r_last == SEL_B))) begin
                        r_state <= GNT_A;
                        r_sel   <= SEL_A;
                    end else if (b_valid) begin
                        r_state <= GNT_B;
                        r_sel   <= SEL_B;
                    end
                end
                GNT_A: begin
                    if (!a_valid || (w_a_xfer && (r_beat_cnt == LAST_BEAT))) begin
                        r_last     <= SEL_A;
                        r_beat_cnt <= '0;
                        if (b_valid) begin
                            r_state <= GNT_B;
                            r_sel   <= SEL_B;
                        end else if (!a_valid) begin
                            r_state <= IDLE;
                        end
                    end else if (w_a_xfer) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                GNT_B: begin
                    if (!b_valid || (w_b_xfer && (r_beat_cnt == LAST_BEAT))) begin
                        r_last     <= SEL_B;
                        r_beat_cnt <= '0;
                        if (a_valid) begin
                            r_state <= GNT_A;
                            r_sel   <= SEL_A;
                        end else if (!b_valid) begin
                            r_state <= IDLE;
                        end
                    end else if (w_b_xfer) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_beat_cnt <= '0;
                end
            endcase
        end
    end

    out_reg_stage #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_data   (w_load_data),
        .i_ready  (y_ready),
        .o_valid  (y_valid),
        .o_data   (y_data),
        .o_accept (w_accept)
    );

    assign sel  = r_sel;
    assign busy = (r_state != IDLE) || y_valid;

`ifdef ARB2_STATS_EN
    logic [15:0] r_cnt_a;
    logic [15:0] r_cnt_b;

    // Saturating accepted-beat counters per requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else begin
            if (w_a_xfer && (r_cnt_a != '1)) begin
                r_cnt_a <= r_cnt_a + 16'd1;
            end
            if (w_b_xfer && (r_cnt_b != '1)) begin
                r_cnt_b <= r_cnt_b + 16'd1;
            end
        end
    end

    assign gnt_cnt_a = r_cnt_a;
    assign gnt_cnt_b = r_cnt_b;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule : arb2_mux_sel_ctrl

// File: tb/tb_arb2_mux_sel_ctrl.sv
// Directed self-checking bench for arb2_mux_sel_ctrl (DATA_W=8, HOLD_MAX=4).
// Requester A streams 0x10,0x11,... and B streams 0x20,0x21,...; each stream
// advances to its next word only after the current word is accepted.
module tb_arb2_mux_sel_ctrl;

    logic       clk;
    logic       rst_n;
    logic       a_valid;
    logic [7:0] a_data;
    logic       a_ready;
    logic       b_valid;
    logic [7:0] b_data;
    logic       b_ready;
    logic       y_valid;
    logic [7:0] y_data;
    logic       y_ready;
    logic       sel;
    logic       busy;
`ifdef ARB2_STATS_EN
    logic [15:0] gnt_cnt_a;
    logic [15:0] gnt_cnt_b;
`endif

    int unsigned n_total;
    int unsigned n_pass;
    int unsigned ia;
    int unsigned ib;

    arb2_mux_sel_ctrl #(
        .DATA_W   (8),
        .HOLD_MAX (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_ready (b_ready),
        .y_valid (y_valid),
        .y_data  (y_data),
        .y_ready (y_ready),
        .sel     (sel),
        .busy    (busy)
`ifdef ARB2_STATS_EN
        ,
        .gnt_cnt_a (gnt_cnt_a),
        .gnt_cnt_b (gnt_cnt_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One clock cycle; requester data advances after an accepted beat.
    task automatic tick();
        logic xa;
        logic xb;
        @(negedge clk);
        xa = a_valid & a_ready;
        xb = b_valid & b_ready;
        @(posedge clk);
        #1;
        if (xa) begin
            ia = ia + 1;
            a_data = 8'(8'h10 + ia);
        end
        if (xb) begin
            ib = ib + 1;
            b_data = 8'(8'h20 + ib);
        end
    endtask

    initial begin
        logic [7:0] exp_d [12];
        logic       exp_s [12];
        logic       exp_s2 [4];

        exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23,
                  8'h14, 8'h15, 8'h16, 8'h17};
        exp_s = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b1};
        exp_s2 = '{1'b1, 1'b1, 1'b1, 1'b0};

        n_total = 0;
        n_pass  = 0;
        ia      = 0;
        ib      = 0;
        rst_n   = 1'b0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = 8'h10;
        b_data  = 8'h20;
        y_ready = 1'b1;

        // Reset held with both requesters valid.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_y_valid", y_valid, 1'b0);
        chk("rst_y_data", y_data, 8'h00);
        chk("rst_sel", sel, 1'b0);
        chk("rst_a_ready", a_ready, 1'b0);
        chk("rst_b_ready", b_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);

        // Release: tie resolves to A on the first edge.
        rst_n = 1'b1;
        tick();
        chk("grant_sel", sel, 1'b0);
        chk("grant_a_ready", a_ready, 1'b1);
        chk("grant_b_ready", b_ready, 1'b0);
        chk("grant_y_valid", y_valid, 1'b0);
        chk("grant_busy", busy, 1'b1);

        // Contention: 4 A, 4 B, 4 A beats, no bubble between grants.
        for (int k = 0; k < 12; k++) begin
            tick();
            chk($sformatf("cont_y_valid[%0d]", k), y_valid, 1'b1);
            chk($sformatf("cont_y_data[%0d]", k), y_data, exp_d[k]);
            chk($sformatf("cont_sel[%0d]", k), sel, exp_s[k]);
        end

        // Backpressure in GNT_B for 3 cycles.
        y_ready = 1'b0;
        #1;
        chk("bp_b_ready", b_ready, 1'b0);
        chk("bp_a_ready", a_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("bp_y_data[%0d]", k), y_data, 8'h17);
            chk($sformatf("bp_y_valid[%0d]", k), y_valid, 1'b1);
            chk($sformatf("bp_sel[%0d]", k), sel, 1'b1);
            chk($sformatf("bp_b_ready_hold[%0d]", k), b_ready, 1'b0);
        end
        y_ready = 1'b1;
        #1;
        chk("bp_release_b_ready", b_ready, 1'b1);
        // B still owes a full 4-beat burst: count did not move while stalled.
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("resume_y_data[%0d]", k), y_data, 8'(8'h24 + k));
            chk($sformatf("resume_sel[%0d]", k), sel, exp_s2[k]);
        end

        // A drops its valid during its grant: B takes over, then B drops too.
        a_valid = 1'b0;
        tick();
        chk("drop_a_sel", sel, 1'b1);
        chk("drop_a_y_valid", y_valid, 1'b0);
        chk("drop_a_b_ready", b_ready, 1'b1);
        tick();
        chk("b_single_y_valid", y_valid, 1'b1);
        chk("b_single_y_data", y_data, 8'h28);
        b_valid = 1'b0;
        tick();
        chk("idle_y_valid", y_valid, 1'b0);
        chk("idle_sel_hold", sel, 1'b1);
        chk("idle_busy", busy, 1'b0);
        tick();
        chk("idle2_a_ready", a_ready, 1'b0);
        chk("idle2_b_ready", b_ready, 1'b0);

        // Idle tie after B was last served: A wins.
        a_valid = 1'b1;
        b_valid = 1'b1;
        tick();
        chk("tie_sel", sel, 1'b0);
        chk("tie_a_ready", a_ready, 1'b1);
        chk("tie_b_ready", b_ready, 1'b0);
        b_valid = 1'b0;

        // Single requester A: 8 back-to-back beats across the 4-beat limit.
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("solo_y_valid[%0d]", k), y_valid, 1'b1);
            chk($sformatf("solo_y_data[%0d]", k), y_data, 8'(8'h18 + k));
            chk($sformatf("solo_sel[%0d]", k), sel, 1'b0);
        end

        // Move to GNT_B with a beat in the output register, then reset mid-cycle.
        a_valid = 1'b0;
        b_valid = 1'b1;
        tick();
        chk("pre_rst_sel", sel, 1'b1);
        tick();
        chk("pre_rst_y_valid", y_valid, 1'b1);
        chk("pre_rst_y_data", y_data, 8'h29);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_y_valid", y_valid, 1'b0);
        chk("async_rst_sel", sel, 1'b0);
        chk("async_rst_a_ready", a_ready, 1'b0);
        chk("async_rst_b_ready", b_ready, 1'b0);
        chk("async_rst_busy", busy, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        b_valid = 1'b0;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_arb2_mux_sel_ctrl
